// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC mode encoding and instruction size shared by the PC unit.
package pc_unit_pkg;
  typedef enum logic [2:0] {
    SEQ     = 3'd0,
    BRANCH  = 3'd1,
    CBRANCH = 3'd2,
    REG     = 3'd3,
    CALL    = 3'd4,
    RET     = 3'd5
  } pc_sel_e;
  localparam int INSN_BYTES = 4;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH     = 64,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top_data,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         full,
  output logic                         empty
);
  localparam int AW = $clog2(RAS_DEPTH);
  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [AW-1:0]    wp, tp;
  assign tp       = wp - 1'b1;
  assign top_data = mem[tp];
  assign full     = count == (AW+1)'(RAS_DEPTH);
  assign empty    = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wp] <= push_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp    <= '0;
      count <= '0;
    end else if (push) begin
      wp    <= wp + 1'b1;
      count <= full ? count : count + 1'b1;
    end else if (pop && !empty) begin
      wp    <= tp;
      count <= count - 1'b1;
    end
endmodule

// File: rtl/pc_unit.sv
// pc_unit: LEGv8 program counter with RAS and exception-PC capture.
// Optional PC_ALIGN_CHECK_EN turns misaligned REG/RET targets into an exception.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int               WIDTH        = 64,
  parameter int               OFFSET_W     = 26,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 'h100,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pc_write_en_in,
  input  logic [2:0]                   pc_sel_in,
  input  logic                         cond_in,
  input  logic [OFFSET_W-1:0]          offset_in,
  input  logic [WIDTH-1:0]             target_in,
  input  logic                         exc_in,
  output logic [WIDTH-1:0]             pc_out,
  output logic [WIDTH-1:0]             pc_plus4_out,
  output logic [WIDTH-1:0]             epc_out,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_out,
  output logic                         ras_hit_out,
  output logic                         misalign_out
);
  logic [WIDTH-1:0] br_tgt, nxt, ras_top;
  logic             commit, is_call, is_ret, ret_hit, mis, ras_empty;
  assign pc_plus4_out = pc_out + WIDTH'(INSN_BYTES);
  assign br_tgt       = pc_out + (WIDTH'($signed(offset_in)) << 2);
  assign commit       = pc_write_en_in && !exc_in;
  assign is_call      = pc_sel_in == CALL;
  assign is_ret       = pc_sel_in == RET;
  assign ret_hit      = is_ret && !ras_empty;
  always_comb
    nxt = (pc_sel_in == BRANCH || is_call)      ? br_tgt :
          (pc_sel_in == CBRANCH && cond_in)     ? br_tgt :
          (pc_sel_in == REG)                    ? target_in :
          ret_hit                               ? ras_top :
          is_ret                                ? target_in :
                                                  pc_plus4_out;
`ifdef PC_ALIGN_CHECK_EN
  assign mis = commit && (nxt[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (commit && is_call),
    .pop       (commit && ret_hit),
    .push_data (pc_plus4_out),
    .top_data  (ras_top),
    .count     (ras_count_out),
    .full      (),
    .empty     (ras_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_out       <= RESET_VECTOR;
      epc_out      <= '0;
      ras_hit_out  <= 1'b0;
      misalign_out <= 1'b0;
    end else begin
      ras_hit_out  <= commit && ret_hit;
      misalign_out <= mis;
      if (exc_in || mis) begin
        pc_out  <= EXC_VECTOR;
        epc_out <= pc_out;
      end else if (pc_write_en_in) begin
        pc_out <= nxt;
      end
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table, hand-written exception/reset sequences, random run against a queue model.
module tb_pc_unit;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        we = 0, cond = 0, exc = 0;
  logic [2:0]  sel = 0;
  logic [25:0] off = 0;
  logic [63:0] tgt = 0;
  logic [63:0] pc_out, pc_plus4_out, epc_out;
  logic [2:0]  ras_count_out;
  logic        ras_hit_out, misalign_out;
  int total = 0, passed = 0;
  logic [63:0] m_pc = 0, m_epc = 0;
  logic        m_hit = 0, m_mis = 0;
  logic [63:0] ras [$];
  localparam logic [63:0] EXC = 64'h100;
  pc_unit dut (
    .clk(clk), .rst_n(rst_n), .pc_write_en_in(we), .pc_sel_in(sel), .cond_in(cond),
    .offset_in(off), .target_in(tgt), .exc_in(exc), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .epc_out(epc_out), .ras_count_out(ras_count_out),
    .ras_hit_out(ras_hit_out), .misalign_out(misalign_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        we;
    logic [2:0]  sel;
    logic        cond;
    logic [25:0] off;
    logic [63:0] tgt;
    logic [63:0] pc;
    int          cnt;
    logic        hit;
  } vec_t;
  vec_t tv [$];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
  endtask
  function automatic logic [63:0] boff(input logic [25:0] o);
    logic signed [63:0] s;
    s = 64'($signed(o));
    return s * 4;
  endfunction
  task automatic model(input logic w, input logic [2:0] s, input logic c, input logic [25:0] o,
                       input logic [63:0] t, input logic e);
    logic [63:0] nt;
    nt = m_pc + 4;
    m_hit = 0;
    m_mis = 0;
    if (w && !e) begin
      case (s)
        3'd1, 3'd4: nt = m_pc + boff(o);
        3'd2: if (c) nt = m_pc + boff(o);
        3'd3: nt = t;
        3'd5: if (ras.size() > 0) begin nt = ras.pop_back(); m_hit = 1; end else nt = t;
        default: ;
      endcase
`ifdef PC_ALIGN_CHECK_EN
      m_mis = nt[1:0] != 2'b00;
`endif
      if (s == 3'd4) begin
        ras.push_back(m_pc + 4);
        if (ras.size() > 4) void'(ras.pop_front());
      end
    end
    if (e || m_mis) begin m_epc = m_pc; m_pc = EXC; end
    else if (w) m_pc = nt;
  endtask
  task automatic step(input logic w, input logic [2:0] s, input logic c, input logic [25:0] o,
                      input logic [63:0] t, input logic e);
    we = w; sel = s; cond = c; off = o; tgt = t; exc = e;
    @(posedge clk);
    model(w, s, c, o, t, e);
    #1;
    chk("pc", pc_out, m_pc);
    chk("pc_plus4", pc_plus4_out, m_pc + 4);
    chk("epc", epc_out, m_epc);
    chk("ras_count", 64'(ras_count_out), 64'(ras.size()));
    chk("ras_hit", 64'(ras_hit_out), 64'(m_hit));
    chk("misalign", 64'(misalign_out), 64'(m_mis));
  endtask
  function automatic void add(input logic w, input logic [2:0] s, input logic c, input logic [25:0] o,
                              input logic [63:0] t, input logic [63:0] p, input int n, input logic h);
    vec_t v;
    v.we = w; v.sel = s; v.cond = c; v.off = o; v.tgt = t; v.pc = p; v.cnt = n; v.hit = h;
    tv.push_back(v);
  endfunction
  initial begin
    add(1, 0, 0, 0, 0, 64'h4, 0, 0);
    add(1, 0, 0, 0, 0, 64'h8, 0, 0);
    add(1, 0, 0, 0, 0, 64'hc, 0, 0);
    add(0, 0, 0, 0, 0, 64'hc, 0, 0);
    add(1, 3, 0, 0, 64'h40, 64'h40, 0, 0);
    add(1, 1, 0, 26'h3fffffc, 0, 64'h30, 0, 0);
    add(1, 2, 0, 26'd8, 0, 64'h34, 0, 0);
    add(1, 2, 1, 26'd8, 0, 64'h54, 0, 0);
    add(1, 3, 0, 0, 64'h10, 64'h10, 0, 0);
    add(1, 4, 0, 26'h10, 0, 64'h50, 1, 0);
    add(1, 5, 0, 0, 64'h999, 64'h14, 0, 1);
    add(1, 5, 0, 0, 64'h200, 64'h200, 0, 0);
    for (int i = 1; i <= 5; i++) add(1, 4, 0, 26'd1, 0, 64'h200 + 64'(4 * i), i > 4 ? 4 : i, 0);
    for (int i = 0; i < 4; i++) add(1, 5, 0, 0, 64'h999, 64'h214 - 64'(4 * i), 3 - i, 1);
    add(1, 5, 0, 0, 64'h300, 64'h300, 0, 0);
    add(1, 7, 0, 0, 0, 64'h304, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc_out, 64'h0);
    chk("rst_epc", epc_out, 64'h0);
    chk("rst_count", 64'(ras_count_out), 64'h0);
    chk("rst_hit", 64'(ras_hit_out), 64'h0);
    rst_n = 1;
    foreach (tv[i]) begin
      step(tv[i].we, tv[i].sel, tv[i].cond, tv[i].off, tv[i].tgt, 0);
      chk($sformatf("tbl%0d_pc", i), pc_out, tv[i].pc);
      chk($sformatf("tbl%0d_cnt", i), 64'(ras_count_out), 64'(tv[i].cnt));
      chk($sformatf("tbl%0d_hit", i), 64'(ras_hit_out), 64'(tv[i].hit));
    end
    step(1, 3, 0, 0, 64'h84, 0);
    step(1, 4, 0, 26'd1, 0, 0);
    chk("call_cnt", 64'(ras_count_out), 64'd1);
    step(0, 4, 0, 26'd1, 0, 1);
    chk("exc_pc", pc_out, 64'h100);
    chk("exc_epc", epc_out, 64'h88);
    chk("exc_cnt", 64'(ras_count_out), 64'd1);
    step(1, 5, 0, 0, 64'h500, 1);
    chk("exc_ret_cnt", 64'(ras_count_out), 64'd1);
    chk("exc_ret_hit", 64'(ras_hit_out), 64'd0);
    chk("exc_ret_epc", epc_out, 64'h100);
    step(1, 3, 0, 0, 64'h20, 0);
    step(1, 3, 0, 0, 64'h202, 0);
`ifdef PC_ALIGN_CHECK_EN
    chk("mis_pc", pc_out, 64'h100);
    chk("mis_epc", epc_out, 64'h20);
    chk("mis_pulse", 64'(misalign_out), 64'd1);
`else
    chk("mis_pc", pc_out, 64'h202);
    chk("mis_pulse", 64'(misalign_out), 64'd0);
`endif
    step(1, 0, 0, 0, 0, 0);
    chk("mis_clear", 64'(misalign_out), 64'd0);
    rst_n = 0;
    #2;
    chk("midrst_pc", pc_out, 64'h0);
    chk("midrst_cnt", 64'(ras_count_out), 64'h0);
    chk("midrst_epc", epc_out, 64'h0);
    m_pc = 0; m_epc = 0; ras.delete();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      logic [63:0] t;
      t = {$urandom, $urandom};
      if ($urandom_range(7) != 0) t[1:0] = 2'b00;
      step($urandom_range(7) != 0, 3'($urandom_range(7)), 1'($urandom),
           26'($signed(7'($urandom))), t, $urandom_range(15) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
